// File: rtl/t05_pkg.sv
// ============================================================================
//  Module   : t05_pkg
//  Brief    : Shared Huffman types, htree node layout and the null-element code.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package t05_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DECODE = 3'd3,
    ST_EMIT   = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_e;

  localparam int IDX_W      = 7;
  localparam int CNT_W      = 16;
  localparam int ELEM_W     = 9;
  localparam int H_ELEM_W   = 71;
  localparam int LEAST1_MSB = 63;
  localparam int LEAST1_LSB = 55;
  localparam int LEAST2_MSB = 54;
  localparam int LEAST2_LSB = 46;

  // Bit 8 set marks a sum node; this one pattern marks an empty slot.
  localparam logic [ELEM_W-1:0] NULL_ELEM = 9'b1_1000_0000;

endpackage

`default_nettype wire

// File: rtl/t05_huff_decoder.sv
// ============================================================================
//  Module   : t05_huff_decoder
//  Brief    : Walks the htree one bit at a time and emits decoded characters.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module t05_huff_decoder
  import t05_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [IDX_W-1:0]    max_index,
  input  logic [CNT_W-1:0]    bit_total,
  input  logic                bit_in,
  input  logic                bit_valid,
  output logic                bit_ready,
  output logic                h_read,
  output logic [IDX_W-1:0]    h_index,
  input  logic                h_valid,
  input  logic [H_ELEM_W-1:0] h_element,
  output logic [7:0]          char_out,
  output logic                char_valid,
  input  logic                char_ready,
  output logic                busy,
  output logic                finished,
  output logic                error,
  output logic [2:0]          state
);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    node_q, node_d;
  logic [IDX_W-1:0]    root_q, root_d;
  logic [CNT_W-1:0]    bits_left_q, bits_left_d;
  logic [ELEM_W-1:0]   least1_q, least1_d;
  logic [ELEM_W-1:0]   least2_q, least2_d;
  logic [7:0]          char_q, char_d;
  logic [ELEM_W-1:0]   child;

  // Only the two child fields of a node word matter to the decoder.
  wire unused_h_bits = ^{h_element[H_ELEM_W-1:LEAST1_MSB+1], h_element[LEAST2_LSB-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      node_q      <= '0;
      root_q      <= '0;
      bits_left_q <= '0;
      least1_q    <= '0;
      least2_q    <= '0;
      char_q      <= '0;
    end else begin
      state_q     <= state_d;
      node_q      <= node_d;
      root_q      <= root_d;
      bits_left_q <= bits_left_d;
      least1_q    <= least1_d;
      least2_q    <= least2_d;
      char_q      <= char_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    node_d      = node_q;
    root_d      = root_q;
    bits_left_d = bits_left_q;
    least1_d    = least1_q;
    least2_d    = least2_q;
    char_d      = char_q;
    child       = bit_in ? least2_q : least1_q;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          node_d      = max_index;
          root_d      = max_index;
          bits_left_d = bit_total;
          state_d     = (bit_total == '0) ? ST_DONE : ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        if (h_valid) begin
          least1_d = h_element[LEAST1_MSB:LEAST1_LSB];
          least2_d = h_element[LEAST2_MSB:LEAST2_LSB];
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (bit_valid) begin
          if (bits_left_q != '0) bits_left_d = bits_left_q - 16'd1;
          if (child == NULL_ELEM) begin
            state_d = ST_ERROR;
          end else if (!child[ELEM_W-1]) begin
            char_d  = child[7:0];
            state_d = ST_EMIT;
          end else if (bits_left_q <= 16'd1) begin
            // Stream ran out while still inside the tree.
            state_d = ST_ERROR;
          end else begin
            node_d  = child[IDX_W-1:0];
            state_d = ST_FETCH;
          end
        end
      end
      ST_EMIT: begin
        if (char_ready) begin
          if (bits_left_q == '0) begin
            state_d = ST_DONE;
          end else begin
            node_d  = root_q;
            state_d = ST_FETCH;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bit_ready  = (state_q == ST_DECODE);
  assign h_read     = (state_q == ST_FETCH);
  assign char_valid = (state_q == ST_EMIT);
  assign busy       = (state_q == ST_FETCH) || (state_q == ST_WAIT) ||
                      (state_q == ST_DECODE) || (state_q == ST_EMIT);
  assign finished   = (state_q == ST_DONE);
  assign error      = (state_q == ST_ERROR);
  assign h_index    = node_q;
  assign char_out   = char_q;
  assign state      = state_q;

endmodule

`default_nettype wire

// File: tb/tb_t05_huff_decoder.sv
// ============================================================================
//  Module   : tb_t05_huff_decoder
//  Brief    : Scoreboard bench for the Huffman decoder with an htree responder.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_t05_huff_decoder;

  logic        clk = 1'b0;
  logic        rst, start, bit_in, bit_valid, h_valid, char_ready;
  logic [6:0]  max_index;
  logic [15:0] bit_total;
  logic [70:0] h_element;
  logic        bit_ready, h_read, char_valid, busy, finished, error;
  logic [6:0]  h_index;
  logic [7:0]  char_out;
  logic [2:0]  state;

  t05_huff_decoder dut (
    .clk(clk), .rst(rst), .start(start), .max_index(max_index), .bit_total(bit_total),
    .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
    .h_read(h_read), .h_index(h_index), .h_valid(h_valid), .h_element(h_element),
    .char_out(char_out), .char_valid(char_valid), .char_ready(char_ready),
    .busy(busy), .finished(finished), .error(error), .state(state)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_fail = 0;
  logic [7:0]  sb_q[$];
  logic        bit_q[$];
  logic [70:0] tree [0:127];
  int          h_delay = 0;
  int          stall_cnt = 0;
  int          h_read_cnt = 0;
  logic        pend = 1'b0;
  int          cnt = 0;
  logic [6:0]  req_idx = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [70:0] mk(input logic [8:0] l1, input logic [8:0] l2);
    logic [70:0] e;
    e = '0;
    e[63:55] = l1;
    e[54:46] = l2;
    return e;
  endfunction

  // Responder, bit source, char sink and scoreboard monitor, all on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      pend       = 1'b0;
      h_valid    = 1'b0;
      bit_valid  = 1'b0;
      char_ready = 1'b0;
    end else begin
      h_valid = 1'b0;
      if (pend) begin
        chk("h_index_hold", 32'(h_index), 32'(req_idx));
        chk("h_read_single", 32'(h_read), 0);
        chk("bit_ready_in_wait", 32'(bit_ready), 0);
        if (cnt == 0) begin
          h_valid   = 1'b1;
          h_element = tree[req_idx];
          pend      = 1'b0;
        end else begin
          cnt--;
        end
      end else if (h_read) begin
        pend    = 1'b1;
        req_idx = h_index;
        cnt     = h_delay;
        h_read_cnt++;
      end

      bit_valid = (bit_q.size() > 0);
      bit_in    = bit_valid ? bit_q[0] : 1'b0;
      if (bit_valid && bit_ready) void'(bit_q.pop_front());

      if (char_valid && stall_cnt > 0) begin
        char_ready = 1'b0;
        stall_cnt--;
        chk("stall_char_out", 32'(char_out), 32'h41);
        chk("stall_no_h_read", 32'(h_read), 0);
      end else begin
        char_ready = 1'b1;
      end
      if (char_valid && char_ready) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL char_unexpected: got %0h expected none", char_out);
        end else begin
          chk("char_out", 32'(char_out), 32'(sb_q.pop_front()));
        end
      end
      chk("strobe_exclusive", 32'(int'(bit_ready) + int'(h_read) + int'(char_valid) <= 1), 1);
    end
  end

  task automatic start_dec(input logic [6:0] idx, input logic [15:0] tot);
    @(posedge clk); #1;
    max_index = idx;
    bit_total = tot;
    start     = 1'b1;
    @(posedge clk); #1;
    start     = 1'b0;
  endtask

  task automatic push_stream(input logic [4:0] bits, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) bit_q.push_back(bits[i]);
  endtask

  task automatic wait_end(input string name, input logic exp_fin, input logic exp_err);
    int i;
    for (i = 0; i < 400; i++) begin
      @(negedge clk);
      if (finished || error) break;
    end
    if (i == 400) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s_timeout: got busy expected finished/error", name);
    end
    chk({name, "_finished"}, 32'(finished), 32'(exp_fin));
    chk({name, "_error"}, 32'(error), 32'(exp_err));
    chk({name, "_chars_left"}, 32'(sb_q.size()), 0);
    chk({name, "_bits_left"}, 32'(bit_q.size()), 0);
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_state"}, 32'(state), 0);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_finished"}, 32'(finished), 0);
    chk({name, "_error"}, 32'(error), 0);
    chk({name, "_bit_ready"}, 32'(bit_ready), 0);
    chk({name, "_h_read"}, 32'(h_read), 0);
    chk({name, "_char_valid"}, 32'(char_valid), 0);
    chk({name, "_char_out"}, 32'(char_out), 0);
    chk({name, "_h_index"}, 32'(h_index), 0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; max_index = '0; bit_total = '0;
    bit_in = 1'b0; bit_valid = 1'b0; h_valid = 1'b0; h_element = '0; char_ready = 1'b0;
    for (int i = 0; i < 128; i++) tree[i] = '0;
    tree[10] = mk(9'h041, 9'h109);  // 'A' | sum -> node 9
    tree[9]  = mk(9'h042, 9'h043);  // 'B' | 'C'
    tree[3]  = mk(9'h05A, 9'h180);  // 'Z' | null

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // A, B, C then finished
    push_stream(5'b01011, 5);
    sb_q.push_back(8'h41); sb_q.push_back(8'h42); sb_q.push_back(8'h43);
    start_dec(7'd10, 16'd5);
    wait_end("abc", 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    chk("done_hold", 32'(finished), 1);

    // Back-pressure on 'A'; a start while busy must be ignored
    stall_cnt = 4;
    push_stream(5'b01011, 5);
    sb_q.push_back(8'h41); sb_q.push_back(8'h42); sb_q.push_back(8'h43);
    start_dec(7'd10, 16'd5);
    for (int i = 0; i < 50 && !char_valid; i++) begin @(posedge clk); #1; end
    start_dec(7'd3, 16'd0);
    wait_end("stall", 1'b1, 1'b0);
    chk("stall_consumed", 32'(stall_cnt), 0);

    // Single-element tree: 'Z' then null
    push_stream(5'b00001, 2);
    sb_q.push_back(8'h5A);
    start_dec(7'd3, 16'd2);
    wait_end("null", 1'b0, 1'b1);
    repeat (3) @(negedge clk);
    chk("error_hold", 32'(error), 1);

    // Exact-length stream vs truncated stream
    push_stream(5'b00010, 2);
    sb_q.push_back(8'h42);
    start_dec(7'd10, 16'd2);
    wait_end("exact", 1'b1, 1'b0);
    push_stream(5'b00001, 1);
    start_dec(7'd10, 16'd1);
    wait_end("trunc", 1'b0, 1'b1);

    // Slow htree: h_valid five cycles late
    h_delay = 5;
    h_read_cnt = 0;
    push_stream(5'b00010, 2);
    sb_q.push_back(8'h42);
    start_dec(7'd10, 16'd2);
    wait_end("slow", 1'b1, 1'b0);
    chk("slow_h_reads", 32'(h_read_cnt), 2);
    h_delay = 0;

    // Zero-length stream
    h_read_cnt = 0;
    start_dec(7'd10, 16'd0);
    wait_end("empty", 1'b1, 1'b0);
    chk("empty_h_reads", 32'(h_read_cnt), 0);

    // Reset during WAIT of the second character, then a clean restart
    push_stream(5'b01011, 5);
    sb_q.push_back(8'h41); sb_q.push_back(8'h42); sb_q.push_back(8'h43);
    start_dec(7'd10, 16'd5);
    begin
      int i;
      for (i = 0; i < 100; i++) begin
        @(posedge clk); #1;
        if (sb_q.size() == 2 && state == 3'd2) break;
      end
      chk("reach_wait2", 32'(i < 100), 1);
    end
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    sb_q.delete();
    bit_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    push_stream(5'b01011, 5);
    sb_q.push_back(8'h41); sb_q.push_back(8'h42); sb_q.push_back(8'h43);
    start_dec(7'd10, 16'd5);
    wait_end("restart", 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/t05_huff_decoder.md
T05_HUFF_DECODER -- requirements
Module: t05_huff_decoder

Interface
REQ-001 SHALL have ports: clk  in  1  clock; rst  in  1  reset (asynchronous, active-high).
REQ-002 SHALL have: start  in  1  one-cycle pulse that begins decode (honoured only in IDLE, DONE or ERROR).
REQ-003 SHALL have: max_index  in  7  htree index of the root node; sampled on start.
REQ-004 SHALL have: bit_total  in  16  number of encoded bits to consume; sampled on start.
REQ-005 SHALL have: bit_in  in  1  encoded bit (0 = left, 1 = right); bit_valid  in  1; bit_ready  out  1.
REQ-006 SHALL have: h_read  out  1  htree read strobe; h_index  out  7  node address; h_valid  in  1  read data valid; h_element  in  71  node word (least1 = [63:55], least2 = [54:46]).
REQ-007 SHALL have: char_out  out  8  decoded character; char_valid  out  1; char_ready  in  1.
REQ-008 SHALL have: busy  out  1; finished  out  1; error  out  1; state  out  3  current state (debug).

Function
REQ-009 SHALL implement the states IDLE, FETCH, WAIT, DECODE, EMIT, DONE and ERROR.
REQ-010 On start, the block SHALL load node = max_index and bits_left = bit_total.
- If bit_total == 0, it SHALL go to DONE.
- Otherwise it SHALL go to FETCH.
REQ-011 In FETCH, the block SHALL assert h_read for exactly one cycle with h_index = node, then go to WAIT.
REQ-012 In WAIT, the block SHALL hold h_index. On h_valid it SHALL latch least1 and least2 and go to DECODE. There is no timeout.
REQ-013 In DECODE, bit_ready SHALL be 1. A bit is consumed only when bit_valid && bit_ready. On consumption:
- child = bit_in ? least2 : least1.
- bits_left decrements by 1.
REQ-014 Child decode in DECODE SHALL be:
- child == 9'b1_1000_0000 (null element): go to ERROR.
- child[8] == 0 (character): char_out = child[7:0], go to EMIT.
- Otherwise (sum node): node = child[6:0], go to FETCH.
REQ-015 If bits_left reaches 0 while the decoder is at a sum node (child is a sum), the block SHALL go to ERROR (truncated stream) instead of FETCH.
REQ-016 In EMIT, char_valid SHALL be 1 and char_out SHALL be stable until char_ready.
- On char_ready with bits_left == 0: go to DONE.
- On char_ready otherwise: node = max_index, go to FETCH.
REQ-017 Per-character latency SHALL be as follows:
- Each tree level costs FETCH (1 cycle) + WAIT (≥1 cycle) + DECODE (≥1 cycle).
- An h_valid on the cycle after h_read plus immediate bit_valid gives 3 cycles per level.
- char_valid rises on the cycle after the final bit is consumed.
REQ-018 busy SHALL be 1 in FETCH, WAIT, DECODE and EMIT. finished SHALL be 1 only in DONE. error SHALL be 1 only in ERROR. DONE and ERROR SHALL hold until start.
REQ-019 A start pulse in any busy state SHALL be ignored. bit_valid outside DECODE SHALL be ignored, and no bit is consumed.
REQ-020 bit_ready, h_read and char_valid SHALL never be asserted in the same cycle.
REQ-021 bits_left SHALL be a 16-bit counter that never wraps. A decrement is only possible when bits_left ≥ 1.

Reset
REQ-022 Reset SHALL set: state = IDLE, node = 0, bits_left = 0, latched least1/least2 = 0, char_out = 0.
REQ-023 Reset SHALL force bit_ready, h_read, char_valid, busy, finished and error to 0.
REQ-024 Reset asserted mid-operation SHALL abandon the decode immediately, with no further h_read or char_valid. A new start is required.

Structure
REQ-025 The state enum, the NULL_ELEM constant (9'b1_1000_0000) and the least1/least2 field bit positions SHALL live in the shared t05 package, shared with the codebook synthesis block.
REQ-026 The block SHALL be a single module with no sub-module. Registered state and next-state logic SHALL be kept separate. All outputs SHALL be driven from registers or from the current state only.

Verification
REQ-027 The bench SHALL cover a tree with root 10 = {least1 = 'A'(0x41), least2 = sum→9} and node 9 = {0x42, 0x43}. Feeding bits 0,1,0,1,1 with bit_total = 5 SHALL emit A, B, C, then finished = 1.
REQ-028 Using the REQ-027 tree, the bench SHALL hold char_ready = 0 for 4 cycles on 'A'. char_out SHALL stay 0x41 with char_valid = 1 throughout, and no h_read SHALL occur.
REQ-029 The bench SHALL cover a single-element tree, root = {0x5A, NULL}. Bits 0,1 with bit_total = 2 SHALL emit 'Z', then error = 1 on the second bit.
REQ-030 Using the REQ-027 tree with bit_total = 2 and bits 1,0, the bench SHALL see 'B' emitted and then finished. With bit_total = 1 and bit 1, it SHALL see error = 1 (truncated stream).
REQ-031 The bench SHALL delay h_valid by 5 cycles. h_index SHALL be held stable, h_read SHALL be a single pulse, and bit_ready SHALL stay 0 until DECODE.
REQ-032 The bench SHALL assert rst during the WAIT of the second character. All outputs SHALL be 0 next cycle, the state SHALL be IDLE, and a re-start SHALL decode correctly from the first bit.
